// File: rtl/single_port_mem.sv
// Single-port synchronous RAM: one read or one write per clock, write-through dout.
// Latency: read data appears on dout one clock after the address is presented.
// Backpressure: none; an access is accepted on every rising edge.
module single_port_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] din,
    input  logic              wen,
    output logic [DATA_W-1:0] dout
);

    // Storage is deliberately left without reset so it maps onto plain RAM
    // and keeps its contents across a reset pulse.
    logic [DATA_W-1:0] mem [DEPTH];

    // Memory write: only on an active (non-reset) edge with wen high.
    always_ff @(posedge clock) begin
        if (rst_n && wen) begin
            mem[address] <= din;
        end
    end

    // Output register: zero on reset, write-through on writes, old contents on reads.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (wen) begin
            dout <= din;
        end else begin
            dout <= mem[address];
        end
    end

endmodule

// File: tb/tb_single_port_mem.sv
// Self-checking bench for single_port_mem: directed scenarios then random traffic.
// Reference model is a plain array plus a written-flag per word.
// Inputs change on the falling edge; dout is sampled 1 time unit after the rising edge.
module tb_single_port_mem;

    logic        clock;
    logic        rst_n;
    logic [7:0]  address;
    logic [15:0] din;
    logic        wen;
    logic [15:0] dout;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [15:0] ref_mem [256];
    bit          ref_vld [256];

    single_port_mem #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .address (address),
        .din     (din),
        .wen     (wen),
        .dout    (dout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One clocked access: model predicts dout, then checks it after the edge
    // and again after scrambling the inputs mid-cycle (dout must hold).
    task automatic step(input bit r, input bit w, input logic [7:0] a,
                        input logic [15:0] d, input string tag);
        logic [15:0] exp;
        bit          known;
        @(negedge clock);
        rst_n   = r;
        wen     = w;
        address = a;
        din     = d;
        if (!r) begin
            exp   = 16'h0000;
            known = 1'b1;
        end else if (w) begin
            ref_mem[a] = d;
            ref_vld[a] = 1'b1;
            exp        = d;
            known      = 1'b1;
        end else begin
            exp   = ref_mem[a];
            known = ref_vld[a];
        end
        @(posedge clock);
        #1;
        if (known) begin
            n_asserts++;
            assert (dout === exp) else begin
                n_fail++;
                $error("FAIL %s: dout=%h expected %h", tag, dout, exp);
            end
        end
        #2;
        wen     = 1'($urandom);
        address = 8'($urandom);
        din     = 16'($urandom);
        #1;
        if (known) begin
            n_asserts++;
            assert (dout === exp) else begin
                n_fail++;
                $error("FAIL %s_hold: dout=%h expected %h", tag, dout, exp);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wen     = 1'b0;
        address = 8'h00;
        din     = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            ref_vld[i] = 1'b0;
            ref_mem[i] = 16'h0000;
        end

        // Reset with a write pending is dropped; contents survive reset.
        step(1'b0, 1'b0, 8'h00, 16'h0000, "rst_init");
        step(1'b1, 1'b1, 8'h00, 16'h0A0A, "wr_00");
        step(1'b0, 1'b1, 8'h00, 16'hFFFF, "rst_wr1");
        step(1'b0, 1'b1, 8'h00, 16'hFFFF, "rst_wr2");
        step(1'b1, 1'b0, 8'h00, 16'h0000, "rd_00_after_rst");

        // Write then read twice with junk din; location unchanged.
        step(1'b1, 1'b1, 8'h11, 16'h0010, "wr_11");
        step(1'b1, 1'b0, 8'h11, 16'h0012, "rd_11_a");
        step(1'b1, 1'b0, 8'h11, 16'h0012, "rd_11_b");
        step(1'b1, 1'b0, 8'h11, 16'h0000, "rd_11_c");

        // Several addresses, read back in a different order.
        step(1'b1, 1'b1, 8'h14, 16'h0013, "wr_14");
        step(1'b1, 1'b1, 8'h16, 16'h0060, "wr_16");
        step(1'b1, 1'b1, 8'h15, 16'h0050, "wr_15");
        step(1'b1, 1'b0, 8'h14, 16'h0000, "rd_14");
        step(1'b1, 1'b0, 8'h15, 16'h0000, "rd_15");
        step(1'b1, 1'b0, 8'h16, 16'h0000, "rd_16");

        // Reset in the middle of traffic.
        step(1'b0, 1'b0, 8'h16, 16'h0000, "rst_mid");
        step(1'b1, 1'b0, 8'h16, 16'h0000, "rd_16_after_rst");

        // Overwrite with neighbours intact.
        step(1'b1, 1'b1, 8'h1F, 16'h1F1F, "wr_1f");
        step(1'b1, 1'b1, 8'h21, 16'h2121, "wr_21");
        step(1'b1, 1'b1, 8'h20, 16'hAAAA, "wr_20_a");
        step(1'b1, 1'b1, 8'h20, 16'h5555, "wr_20_b");
        step(1'b1, 1'b0, 8'h20, 16'h0000, "rd_20");
        step(1'b1, 1'b0, 8'h1F, 16'h0000, "rd_1f");
        step(1'b1, 1'b0, 8'h21, 16'h0000, "rd_21");

        // Address boundaries.
        step(1'b1, 1'b1, 8'h00, 16'h1234, "wr_00_b");
        step(1'b1, 1'b1, 8'hFF, 16'hBEEF, "wr_ff");
        step(1'b1, 1'b0, 8'h00, 16'h0000, "rd_00_b");
        step(1'b1, 1'b0, 8'hFF, 16'h0000, "rd_ff");

        // Random traffic over a small address window so reads often hit written words.
        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            logic [7:0]  a;
            op = $urandom_range(0, 19);
            a  = 8'($urandom_range(0, 31)) + ((op[0]) ? 8'hE0 : 8'h00);
            if (op == 0)
                step(1'b0, 1'($urandom), a, 16'($urandom), "rnd_rst");
            else if (op < 9)
                step(1'b1, 1'b1, a, 16'($urandom), "rnd_wr");
            else
                step(1'b1, 1'b0, a, 16'($urandom), "rnd_rd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/single_port_mem.md
SINGLE_PORT_MEM -- requirements
Module: single_port_mem

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter DATA_W, default 16, data word width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_W, number of words; SHALL equal 2**ADDR_W.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 address  input  ADDR_W  word address for read and write.
REQ-007 din  input  DATA_W  write data.
REQ-008 wen  input  1  write enable, active-high; 0 selects read.
REQ-009 dout  output  DATA_W  registered read data.

Function
REQ-010 Storage SHALL be DEPTH words of DATA_W bits, one shared port: one access (read or write) per clock.
REQ-011 Write: on a rising edge with rst_n=1 and wen=1, mem[address] SHALL take din.
REQ-012 Write SHALL be write-through: on that same edge dout SHALL take din.
REQ-013 Read: on a rising edge with rst_n=1 and wen=0, dout SHALL take mem[address] (value before the edge); memory unchanged.
REQ-014 Read latency SHALL be exactly 1 clock: address presented before edge N appears on dout after edge N.
REQ-015 With wen=0, din SHALL be ignored; no memory location SHALL change.
REQ-016 dout SHALL hold its value between rising edges; no combinational path from address, din or wen to dout.
REQ-017 All DEPTH addresses 0 to DEPTH-1 SHALL be valid; no wrap, aliasing or out-of-range case exists.
REQ-018 Back-to-back write then read of the same address SHALL return the newly written word on the read.
REQ-019 Consecutive writes to different addresses SHALL not disturb any other location.
REQ-020 Contents of never-written locations SHALL be don't-care after power-up; benches SHALL NOT check them.
REQ-021 Input changes between edges SHALL have no effect until the next rising edge.

Reset
REQ-022 On a rising edge with rst_n=0, dout SHALL become all zeros, regardless of wen, address and din.
REQ-023 Reset SHALL NOT write or clear memory contents; words written before reset SHALL read back unchanged afterwards.
REQ-024 A write request (wen=1) on a reset edge SHALL be dropped.
REQ-025 The first access SHALL be the first rising edge with rst_n=1; behaviour is then per REQ-011 to REQ-021.

Verification
REQ-026 Reset: rst_n=0 for 2 edges, wen=1, din=16'hFFFF, address=8'h00 -> dout=16'h0000; a later read of 8'h00 returns the earlier contents, not 16'hFFFF.
REQ-027 Write/readback: write 16'h0010 @8'h11, then wen=0 with din=16'h0012 @8'h11 -> dout=16'h0010 on both edges; mem[8'h11] stays 16'h0010.
REQ-028 Multi-address: write 16'h0013 @8'h14, 16'h0060 @8'h16, 16'h0050 @8'h15; then read 8'h14, 8'h15, 8'h16 -> 16'h0013, 16'h0050, 16'h0060, each one cycle after its address.
REQ-029 Overwrite: write 16'hAAAA then 16'h5555 @8'h20, read 8'h20 -> 16'h5555; neighbours 8'h1F and 8'h21 unchanged.
REQ-030 Boundaries: write 16'h1234 @8'h00 and 16'hBEEF @8'hFF, read both -> exact values, no aliasing.
REQ-031 Reset mid-operation: after REQ-028 writes, assert rst_n=0 for 1 edge -> dout=16'h0000; then read 8'h16 -> 16'h0060.
